// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory bank.
package imem_pkg;

    // Controller states: clearing the array after reset, then serving traffic.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    // Widest instruction word the NOP constant is defined for.
    localparam int unsigned MAX_DATA_WIDTH = 128;

    // NOP encoding written into every word during the clear sequence.
    localparam logic [MAX_DATA_WIDTH-1:0] NOP = '0;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port and NUM_PORTS independent
// synchronous read-first read ports with registered outputs.
module imem_array
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [NUM_PORTS-1:0]            rd_en,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q [NUM_PORTS];

    // Storage write; contents are never reset, only overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Per-port read register; samples the pre-edge word so a same-edge write is not seen.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_q[p] <= '0;
            end else if (rd_en[p]) begin
                rd_q[p] <= mem[rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rd_q[p];
    end

endmodule

// File: rtl/imem_bank.sv
// Multi-port instruction memory bank: clears itself to NOP after reset, then
// accepts program writes and serves independent one-cycle-latency reads.
module imem_bank
    import imem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_PORTS-1:0]            rd_valid,
    input  logic                            prog_valid,
    output logic                            prog_ready,
    input  logic [ADDR_WIDTH-1:0]           prog_addr,
    input  logic [DATA_WIDTH-1:0]           prog_data,
    output logic                            init_done
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_PORTS-1:0]  rd_en;

    assign ready      = (state == READY);
    assign prog_ready = ready;
    assign rd_en      = rd_req & {NUM_PORTS{ready}};

    // Controller: walk the clear counter across every word, then stay READY until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            clear_cnt <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
                    if (&clear_cnt) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= INIT;
                    clear_cnt <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // Write port source: clear sequence during INIT, accepted program writes afterwards.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = prog_addr;
        wr_data = prog_data;
        if (!ready) begin
            wr_en   = 1'b1;
            wr_addr = clear_cnt;
            wr_data = NOP[DATA_WIDTH-1:0];
        end else if (prog_valid) begin
            wr_en   = 1'b1;
        end
    end

    // Valid pulses follow accepted read requests by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_PORTS  (NUM_PORTS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_imem_bank.sv
// Directed testbench for imem_bank with a behavioural memory model and
// a per-cycle compare process.
module tb_imem_bank;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NP    = 2;
    localparam int DEPTH = 64;

    logic             clk;
    logic             rst;
    logic [NP-1:0]    rd_req;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]    rd_valid;
    logic             prog_valid;
    logic             prog_ready;
    logic [AW-1:0]    prog_addr;
    logic [DW-1:0]    prog_data;
    logic             init_done;

    int check_count = 0;
    int error_count = 0;

    imem_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_PORTS  (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .init_done  (init_done)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: memory array, edges since reset release, expected read outputs
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_data [NP];
    logic [NP-1:0] m_valid;
    int            m_edges;
    logic          model_live = 1'b0;

    // Model update: reset wipes everything; after DEPTH edges reads/writes are served read-first
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_live = 1'b1;
            m_edges = 0;
            m_valid = '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            for (int p = 0; p < NP; p++) m_data[p] = '0;
        end else if (m_edges >= DEPTH) begin
            for (int p = 0; p < NP; p++) begin
                m_valid[p] = rd_req[p];
                if (rd_req[p]) m_data[p] = m_mem[int'(rd_addr[p*AW +: AW])];
            end
            if (prog_valid) m_mem[int'(prog_addr)] = prog_data;
        end else begin
            m_valid = '0;
            m_edges++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("init_done", 64'(init_done), 64'(m_edges >= DEPTH && !rst));
            checkOutput("prog_ready", 64'(prog_ready), 64'(m_edges >= DEPTH && !rst));
            checkOutput("rd_valid", 64'(rd_valid), 64'(m_valid));
            for (int p = 0; p < NP; p++) begin
                checkOutput($sformatf("rd_data%0d", p), 64'(rd_data[p*DW +: DW]), 64'(m_data[p]));
            end
        end
    end

    task automatic applyStimulus(input logic [NP-1:0] req, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        rd_req     = req;
        rd_addr    = {a1, a0};
        prog_valid = pv;
        prog_addr  = pa;
        prog_data  = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
    endtask

    task automatic waitInit(input int already);
        int n;
        n = already;
        while (!init_done && n < 200) begin
            idle();
            n++;
        end
        checkOutput("init_edges", 64'(n), 64'd64);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        rd_req     = '0;
        rd_addr    = '0;
        prog_valid = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        #2;
        pulseReset();

        // Reset in the middle of the clear sequence restarts it
        for (int i = 0; i < 10; i++) idle();
        checkOutput("midinit_done", 64'(init_done), 64'd0);
        pulseReset();

        // Reads and a program attempt during INIT are ignored
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 6'd7, 6'd9, 1'b1, 6'd7, 32'hDEADBEEF);
            checkOutput("init_rd_valid", 64'(rd_valid), 64'd0);
            checkOutput("init_prog_ready", 64'(prog_ready), 64'd0);
        end
        waitInit(3);
        checkOutput("ready_prog_ready", 64'(prog_ready), 64'd1);

        // Cleared words read as NOP
        applyStimulus(2'b11, 6'd5, 6'd63, 1'b0, 6'd0, 32'h0);
        checkOutput("clr_valid", 64'(rd_valid), 64'h3);
        checkOutput("clr_data", 64'(rd_data), 64'h0);
        applyStimulus(2'b01, 6'd7, 6'd0, 1'b0, 6'd0, 32'h0);
        checkOutput("init_write_ignored", 64'(rd_data[DW-1:0]), 64'h0);
        idle();
        checkOutput("valid_drops", 64'(rd_valid), 64'h0);

        // Program two words, then read both in the same cycle
        applyStimulus(2'b00, 6'd0, 6'd0, 1'b1, 6'd0, 32'h34080005);
        applyStimulus(2'b00, 6'd0, 6'd0, 1'b1, 6'd1, 32'h3409000A);
        applyStimulus(2'b11, 6'd0, 6'd1, 1'b0, 6'd0, 32'h0);
        checkOutput("prog_p0", 64'(rd_data[DW-1:0]), 64'h34080005);
        checkOutput("prog_p1", 64'(rd_data[2*DW-1:DW]), 64'h3409000A);

        // Same-edge write and read returns the old word
        applyStimulus(2'b01, 6'd2, 6'd0, 1'b1, 6'd2, 32'h01095021);
        checkOutput("rfirst_old", 64'(rd_data[DW-1:0]), 64'h0);
        checkOutput("rfirst_valid", 64'(rd_valid), 64'h1);
        checkOutput("rfirst_p1_hold", 64'(rd_data[2*DW-1:DW]), 64'h3409000A);
        applyStimulus(2'b01, 6'd2, 6'd0, 1'b0, 6'd0, 32'h0);
        checkOutput("rfirst_new", 64'(rd_data[DW-1:0]), 64'h01095021);

        // Back-to-back reads of one address on both ports
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b11, 6'd1, 6'd1, 1'b0, 6'd0, 32'h0);
            checkOutput("b2b_valid", 64'(rd_valid), 64'h3);
            checkOutput("b2b_data", 64'(rd_data), {32'h3409000A, 32'h3409000A});
        end
        idle();
        checkOutput("b2b_end_valid", 64'(rd_valid), 64'h0);
        checkOutput("b2b_hold", 64'(rd_data), {32'h3409000A, 32'h3409000A});

        // Reset while READY: outputs clear at once, contents lost after re-init
        applyStimulus(2'b11, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0);
        checkOutput("pre_rst_data", 64'(rd_data), {32'h34080005, 32'h34080005});
        rst = 1'b1;
        #1;
        checkOutput("rst_valid", 64'(rd_valid), 64'h0);
        checkOutput("rst_data", 64'(rd_data), 64'h0);
        checkOutput("rst_ready", 64'({prog_ready, init_done}), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitInit(0);
        applyStimulus(2'b11, 6'd0, 6'd2, 1'b0, 6'd0, 32'h0);
        checkOutput("post_rst_valid", 64'(rd_valid), 64'h3);
        checkOutput("post_rst_data", 64'(rd_data), 64'h0);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
